mips_reg_file_mp: RTL
=====================

# mips_reg_file_mp

Parametrised multi-read-port register file with an integrated write-pending scoreboard, the successor of the single-cycle `reg_file` used by the MIPS datapath. It provides NUM_RD combinational read ports, one clocked write-back port, and per-register busy bits that the issue logic sets when an instruction that writes a register is issued. Write-back clears those bits, which lets a pipelined or multi-issue datapath detect RAW hazards without a separate scoreboard block.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..8)
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- rd_addr  input  NUM_RD*ADDR_W  read addresses; port i is at [i*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  read data; port i is at [i*DATA_W +: DATA_W]
- rd_busy  output  NUM_RD  scoreboard bit of the register addressed by port i
- wr_en  input  1  write-back strobe
- wr_addr  input  ADDR_W  write-back register
- wr_data  input  DATA_W  write-back data
- rsv_en  input  1  reservation request: mark rsv_addr pending
- rsv_addr  input  ADDR_W  register to reserve
- rsv_ok  output  1  reservation accepted this cycle
- busy_vec  output  2**ADDR_W  all scoreboard bits; bit 0 is always 0
- pend_cnt  output  ADDR_W+1  number of registers currently busy

## Operation
- Storage: 2**ADDR_W x DATA_W array. Register 0 reads 0 at all times. Writes to register 0 are discarded.
- Reads are combinational from the array: rd_data[i] = reg[rd_addr[i]], and rd_busy[i] = busy[rd_addr[i]].
- Write: when wr_en=1 and wr_addr≠0, reg[wr_addr] takes wr_data at the edge and busy[wr_addr] is cleared.
- Reservation: rsv_ok = rsv_en & (rsv_addr==0 | ~busy[rsv_addr] | (wr_en & wr_addr==rsv_addr)).
  - When rsv_ok=1 and rsv_addr≠0, busy[rsv_addr] is set at the edge.
  - When rsv_ok=0 the request is ignored, and the issuer must stall and retry.
- Simultaneous write and reservation to the same register: the data is written and the reservation wins, so busy stays 1 (WAW re-issue).
- Simultaneous write and reservation to different registers: both take effect.
- pend_cnt is a registered popcount of busy:
  - +1 when a reservation sets a bit that was 0.
  - −1 when a write clears a bit that was 1.
  - Net 0 for the same-register case above.
- pend_cnt always equals the popcount of busy_vec, and it never exceeds 2**ADDR_W−1.
- A write to a non-busy register is legal. It updates data and leaves busy and pend_cnt unchanged.

## Timing
- Reset (asserted asynchronously) sets all registers to 0, busy_vec to 0 and pend_cnt to 0. As a result, rd_data=0, rd_busy=0 and rsv_ok=rsv_en for as long as rst is high.
- Reset mid-operation discards all pending reservations. Inputs sampled at edges while rst=1 have no effect.
- Read latency is 0 cycles, combinational from rd_addr.
- Write latency is 1 cycle: data becomes visible on rd_data after the rising edge that samples wr_en, unless bypass is enabled.
- busy, rsv_ok effects and pend_cnt update at the same edge as the write.
- rsv_ok is combinational from rsv_*, wr_* and the busy state.

## Configuration
- REG_FILE_BYPASS_EN defined:
  - Each read port forwards same-cycle write-back data: if wr_en=1, wr_addr≠0 and rd_addr[i]==wr_addr, then rd_data[i]=wr_data and rd_busy[i]=0.
  - Exception: if a same-register reservation is also accepted that cycle, rd_busy[i]=1.
- REG_FILE_BYPASS_EN undefined:
  - Reads return only array contents and the current busy bit.
  - The forwarding comparators are not built.

## Test plan
- Reset: write 0xDEADBEEF to r5, then assert rst asynchronously between edges → rd_data for r5 becomes 0 immediately, busy_vec=0, pend_cnt=0.
- r0 protection: write 0x12345678 to r0 and reserve r0 → port 0 reading r0 returns 0, rsv_ok=1, busy_vec[0]=0, pend_cnt=0.
- Scoreboard flow: reserve r3 → next cycle rd_busy=1 on a port reading r3 and pend_cnt=1. Reserve r3 again with no write → rsv_ok=0. Write r3=0xA5A5A5A5 → next cycle rd_data=0xA5A5A5A5, rd_busy=0, pend_cnt=0.
- Same-register collision: r7 busy, write r7=0x11 and reserve r7 in the same cycle → rsv_ok=1. Next cycle rd_data=0x11, busy[7]=1, pend_cnt unchanged at 1.
- Multi-port (NUM_RD=4): fill r1..r4 with 0x1..0x4, read r4, r3, r2, r1 on ports 0..3 → rd_data = {0x1, 0x2, 0x3, 0x4} (port 3 in the MSBs).
- Bypass: write r9=0xCAFE while reading r9.
  - With REG_FILE_BYPASS_EN: same-cycle rd_data=0xCAFE.
  - Without REG_FILE_BYPASS_EN: the old value is returned until the edge.

Source files
------------

// File: rtl/mips_reg_file_mp.sv
// ---------------------------------------------------------------------------
// mips_reg_file_mp
// Multi-read-port MIPS register file with an integrated write-pending
// scoreboard. Issue logic reserves a destination register (busy bit set);
// write-back stores the data and clears the busy bit. Readers get both the
// register value and its busy bit, so RAW hazards can be detected directly
// from the read ports.
//
// Optional feature (compile-time macro):
//   REG_FILE_BYPASS_EN - read ports forward same-cycle write-back data.
//
// Parameters:
//   DATA_W   register width in bits
//   ADDR_W   register address width (depth = 2**ADDR_W)
//   NUM_RD   number of combinational read ports (1..8)
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       asynchronous active-high reset
//   rd_addr   packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data   packed read data, port i at [i*DATA_W +: DATA_W] (comb)
//   rd_busy   busy bit of the register addressed by each port (comb)
//   wr_en     write-back strobe
//   wr_addr   write-back register
//   wr_data   write-back data
//   rsv_en    reservation request for rsv_addr
//   rsv_addr  register to reserve
//   rsv_ok    reservation accepted this cycle (comb)
//   busy_vec  all scoreboard bits, bit 0 always 0 (registered)
//   pend_cnt  number of busy registers (registered)
// ---------------------------------------------------------------------------
module mips_reg_file_mp #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NUM_RD = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       rsv_en,
   input  logic [ADDR_W-1:0]          rsv_addr,
   output logic                       rsv_ok,
   output logic [(2**ADDR_W)-1:0]     busy_vec,
   output logic [ADDR_W:0]            pend_cnt
);

   localparam int unsigned DEPTH = 2**ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   // Architectural state
   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [CNT_W-1:0]  pend_cnt_q, pend_cnt_d;

   // Per-cycle decode
   logic              wr_hit_c;
   logic              rsv_take_c;
   logic              same_reg_c;
   logic              cnt_inc_c;
   logic              cnt_dec_c;

   // Unpacked view of the read addresses
   logic [ADDR_W-1:0] rd_addr_a [NUM_RD];

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_unpack
      assign rd_addr_a[g] = rd_addr[g*ADDR_W +: ADDR_W];
   end

   // Reservation acceptance: free register, r0, or freed by this cycle's write
   assign rsv_ok = rsv_en & ((rsv_addr == '0) | ~busy_q[rsv_addr] |
                             (wr_en & (wr_addr == rsv_addr)));

   assign wr_hit_c   = wr_en & (wr_addr != '0);
   assign rsv_take_c = rsv_ok & (rsv_addr != '0);
   assign same_reg_c = wr_hit_c & rsv_take_c & (wr_addr == rsv_addr);

   // Counter deltas track only real 0->1 and 1->0 transitions of busy.
   // On a same-register collision the reservation wins, so the write never
   // clears the bit and contributes no decrement.
   assign cnt_inc_c = rsv_take_c & ~busy_q[rsv_addr];
   assign cnt_dec_c = wr_hit_c & busy_q[wr_addr] & ~same_reg_c;

   // Scoreboard next state: clear on write-back, then set on reservation
   always_comb begin
      busy_d     = busy_q;
      pend_cnt_d = pend_cnt_q;
      if (wr_hit_c) begin
         busy_d[wr_addr] = 1'b0;
      end
      if (rsv_take_c) begin
         busy_d[rsv_addr] = 1'b1;
      end
      busy_d[0]  = 1'b0;
      pend_cnt_d = pend_cnt_q + CNT_W'(cnt_inc_c) - CNT_W'(cnt_dec_c);
   end

   // Scoreboard state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q     <= '0;
         pend_cnt_q <= '0;
      end else begin
         busy_q     <= busy_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   // Register array; r0 is never written so it stays at its reset value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_hit_c) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   // Read ports
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (rd_addr_a[i] != '0) begin
            rd_data[i*DATA_W +: DATA_W] = regs_q[rd_addr_a[i]];
            rd_busy[i]                  = busy_q[rd_addr_a[i]];
         end
`ifdef REG_FILE_BYPASS_EN
         // Forward write-back data; busy stays set only if a same-register
         // reservation is re-issued in this very cycle.
         if (wr_hit_c && (rd_addr_a[i] == wr_addr)) begin
            rd_data[i*DATA_W +: DATA_W] = wr_data;
            rd_busy[i]                  = same_reg_c;
         end
`endif
      end
   end

   assign busy_vec = busy_q;
   assign pend_cnt = pend_cnt_q;

endmodule
